// File: rtl/instr_mem_pkg.sv
// Shared constants for the programmable instruction memory: sizes, FSM state codes
// and the default ramen-timer program image (used when ROM_DEFAULT_EN is defined).
package instr_mem_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int MEM_WIDTH = 8;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [7:0] ROM_IMAGE [0:15] = '{
        8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
        8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF
    };

endpackage

// File: rtl/instr_mem_array.sv
// 16x8 register file: one synchronous write port, one asynchronous read port.
// With ROM_DEFAULT_EN defined, n_reset loads the default program image.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int WIDTH = MEM_WIDTH
) (
    input  logic             clk,
`ifdef ROM_DEFAULT_EN
    input  logic             n_reset,
`endif
    input  logic             we,
    input  logic [3:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [3:0]       raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

`ifdef ROM_DEFAULT_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(ROM_IMAGE[i]);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
`else
    // No reset on storage: contents are whatever the host last loaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end
`endif

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Host-loadable instruction memory for the 4-bit CPU; holds the CPU in reset while loading.
// Optional macro ROM_DEFAULT_EN: reset loads the default ramen-timer image.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int WIDTH = MEM_WIDTH
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             prog_mode,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [3:0]       address,
    output logic [WIDTH-1:0] instr,
    output logic             cpu_n_reset,
    output logic             load_done,
    output logic [3:0]       wr_ptr
);

    logic [1:0] state;
    logic [1:0] next_state;
    logic       accept;

    assign din_ready = (state == ST_LOAD) && prog_mode;
    assign accept    = din_valid && din_ready;

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:  if (prog_mode) next_state = ST_LOAD;
            ST_LOAD: begin
                if (!prog_mode)
                    next_state = ST_RUN;
                else if (accept && wr_ptr == 4'd15)
                    next_state = ST_HOLD;
            end
            ST_HOLD: if (!prog_mode) next_state = ST_RUN;
            default: next_state = ST_RUN;
        endcase
    end

    // cpu_n_reset follows the next state so the CPU is released on the same edge the FSM returns to RUN.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= ST_RUN;
            wr_ptr      <= 4'd0;
            load_done   <= 1'b0;
            cpu_n_reset <= 1'b0;
        end else begin
            state       <= next_state;
            cpu_n_reset <= (next_state == ST_RUN);
            if (state == ST_RUN && prog_mode) begin
                wr_ptr    <= 4'd0;
                load_done <= 1'b0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + 4'd1;
                if (wr_ptr == 4'd15)
                    load_done <= 1'b1;
            end
        end
    end

    instr_mem_array #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
`ifdef ROM_DEFAULT_EN
        .n_reset (n_reset),
`endif
        .we      (accept),
        .waddr   (wr_ptr),
        .wdata   (din),
        .raddr   (address),
        .rdata   (instr)
    );

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model of the loader.
module tb_instr_mem_loader;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       prog_mode;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] address;
    logic [7:0] instr;
    logic       cpu_n_reset;
    logic       load_done;
    logic [3:0] wr_ptr;

    int tests = 0;
    int fails = 0;

    instr_mem_loader dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .prog_mode   (prog_mode),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .address     (address),
        .instr       (instr),
        .cpu_n_reset (cpu_n_reset),
        .load_done   (load_done),
        .wr_ptr      (wr_ptr)
    );

    always #5 clk = ~clk;

    // Behavioural model: "loading" means the host session is open and not yet full,
    // "held" means a full program has been received and the session is still open.
    logic [7:0] m_mem [16];
    bit         m_known [16];
    bit         m_loading, m_held, m_released, m_done;
    int         m_ptr;
    bit         m_ready_exp;

    initial begin
        for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
`ifdef ROM_DEFAULT_EN
        begin
            logic [7:0] img [16] = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                                     8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
            for (int i = 0; i < 16; i++) begin m_mem[i] = img[i]; m_known[i] = 1'b1; end
        end
`endif
    end

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_loading = 0; m_held = 0; m_released = 0; m_done = 0; m_ptr = 0;
        end else begin
            bit acc;
            bit last;
            acc  = m_loading && prog_mode && din_valid;
            last = acc && (m_ptr == 15);
            if (acc) begin
                m_mem[m_ptr]   = din;
                m_known[m_ptr] = 1'b1;
                m_ptr          = (m_ptr + 1) % 16;
            end
            if (!prog_mode) begin
                m_loading = 0; m_held = 0;
            end else if (!m_loading && !m_held) begin
                m_loading = 1; m_ptr = 0; m_done = 0;
            end else if (last) begin
                m_loading = 0; m_held = 1; m_done = 1;
            end
            m_released = !(m_loading || m_held);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (n_reset === 1'b1) begin
            m_ready_exp = m_loading && prog_mode;
            chk("model.din_ready", din_ready, m_ready_exp);
            chk("model.cpu_n_reset", cpu_n_reset, m_released);
            chk("model.load_done", load_done, m_done);
            chk("model.wr_ptr", wr_ptr, m_ptr);
            if (m_known[address]) chk("model.instr", instr, m_mem[address]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input int a, input int exp, input string name);
        address = a[3:0];
        #1;
        chk(name, instr, exp);
    endtask

    initial begin
        n_reset = 1'b0; prog_mode = 1'b0; din = 8'h00; din_valid = 1'b0; address = 4'd0;
        #12;
        chk("rst.cpu_n_reset", cpu_n_reset, 0);
        chk("rst.wr_ptr", wr_ptr, 0);
        chk("rst.load_done", load_done, 0);
        chk("rst.din_ready", din_ready, 0);
        n_reset = 1'b1;
        tick();
        chk("rst.release", cpu_n_reset, 1);
`ifdef ROM_DEFAULT_EN
        peek(0, 8'hB7, "rom.w0");
        peek(15, 8'hFF, "rom.w15");
`endif

        // Full load 0x10..0x1F streamed back to back.
        prog_mode = 1'b1;
        tick();
        chk("load.cpu_held", cpu_n_reset, 0);
        chk("load.ready", din_ready, 1);
        din_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 8'h10 + 8'(i);
            tick();
        end
        din_valid = 1'b0;
        chk("load.done", load_done, 1);
        chk("load.ptr_wrap", wr_ptr, 0);
        chk("load.hold_ready", din_ready, 0);
        chk("load.hold_cpu", cpu_n_reset, 0);

        // HOLD ignores further bytes.
        din = 8'h55; din_valid = 1'b1;
        #1 chk("hold.ready", din_ready, 0);
        tick();
        din_valid = 1'b0;
        peek(0, 8'h10, "hold.w0");
        prog_mode = 1'b0;
        tick();
        chk("hold.release", cpu_n_reset, 1);
        peek(5, 8'h15, "load.w5");

        // Abort after three bytes.
        prog_mode = 1'b1;
        tick();
        din_valid = 1'b1;
        din = 8'hAA; tick();
        din = 8'hBB; tick();
        din = 8'hCC; tick();
        din_valid = 1'b0; prog_mode = 1'b0;
        tick();
        chk("abort.release", cpu_n_reset, 1);
        chk("abort.done", load_done, 0);
        chk("abort.ptr", wr_ptr, 3);
        peek(0, 8'hAA, "abort.w0");
        peek(2, 8'hCC, "abort.w2");
        peek(3, 8'h13, "abort.w3");

        // prog_mode falls together with a valid byte at wr_ptr 4.
        prog_mode = 1'b1;
        tick();
        din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin din = 8'hA0 + 8'(i); tick(); end
        prog_mode = 1'b0; din = 8'h77;
        #1 chk("simul.ready", din_ready, 0);
        tick();
        din_valid = 1'b0;
        chk("simul.ptr", wr_ptr, 4);
        chk("simul.release", cpu_n_reset, 1);
        peek(4, 8'h14, "simul.w4");

        // Sparse valid: one pulse every third cycle.
        prog_mode = 1'b1;
        tick();
        for (int p = 0; p < 6; p++) begin
            din_valid = 1'b1; din = 8'hC0 + 8'(p);
            tick();
            din_valid = 1'b0;
            tick();
            tick();
        end
        chk("sparse.ptr", wr_ptr, 6);
        peek(5, 8'hC5, "sparse.w5");
        peek(6, 8'h16, "sparse.w6");

        // Asynchronous reset in the middle of a load, between clock edges.
        din_valid = 1'b0;
        din = 8'hD0;
        din_valid = 1'b1;
        tick();
        din = 8'hD1;
        tick();
        din_valid = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        chk("areset.ptr", wr_ptr, 0);
        chk("areset.done", load_done, 0);
        chk("areset.cpu", cpu_n_reset, 0);
        chk("areset.ready", din_ready, 0);
`ifndef ROM_DEFAULT_EN
        peek(7, 8'hD1, "areset.keep");
`endif
        prog_mode = 1'b0;
        #2 n_reset = 1'b1;
        tick();
        chk("areset.release", cpu_n_reset, 1);

        // Randomized traffic; prog_mode changes rarely so full loads do occur.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) prog_mode = ~prog_mode;
            din_valid = ($urandom_range(0, 3) != 0);
            din       = 8'($urandom);
            address   = 4'($urandom);
            tick();
        end
        prog_mode = 1'b0; din_valid = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
